// File: rtl/bus_rw_strobe_ctrl.sv
// Parallel-bus read/write strobe sequencer: setup, strobe pulse, hold.
// One access at a time; done pulses one cycle when the access completes.
module bus_rw_strobe_ctrl #(
    parameter int          DATA_W    = 8,
    parameter logic [13:0] SETUP_CYC = 14'd2,
    parameter logic [13:0] PULSE_CYC = 14'd3,
    parameter logic [13:0] HOLD_CYC  = 14'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              rw,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_rw,
    output logic              bus_en,
    output logic              bus_oe,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    // Zero-length phases are stretched to one cycle.
    localparam logic [13:0] S_LAST =
        (SETUP_CYC == 14'd0) ? 14'd0 : SETUP_CYC - 14'd1;
    localparam logic [13:0] P_LAST =
        (PULSE_CYC == 14'd0) ? 14'd0 : PULSE_CYC - 14'd1;
    localparam logic [13:0] H_LAST =
        (HOLD_CYC == 14'd0) ? 14'd0 : HOLD_CYC - 14'd1;

    state_t      state_q;
    state_t      state_d;
    logic [13:0] cnt_q;
    logic [13:0] cnt_d;
    logic        accept;
    logic        to_hold;
    logic        to_idle;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req)             state_d = SETUP;
            SETUP: if (cnt_q == S_LAST) state_d = PULSE;
            PULSE: if (cnt_q == P_LAST) state_d = HOLD;
            HOLD:  if (cnt_q == H_LAST) state_d = IDLE;
        endcase
    end

    // Counter clears on every phase change, so it can never wrap.
    always_comb begin
        cnt_d = 14'd0;
        if (state_q != IDLE && state_d == state_q)
            cnt_d = cnt_q + 14'd1;
    end

    assign accept  = (state_q == IDLE) && req;
    assign to_hold = (state_q == PULSE) && (state_d == HOLD);
    assign to_idle = (state_q == HOLD) && (state_d == IDLE);
    assign ready   = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 14'd0;
            done     <= 1'b0;
            rdata    <= '0;
            bus_rw   <= 1'b0;
            bus_en   <= 1'b0;
            bus_oe   <= 1'b0;
            bus_dout <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= to_idle;
            bus_en  <= (state_d == PULSE);
            if (accept) begin
                bus_rw   <= rw;
                bus_dout <= wdata;
                bus_oe   <= ~rw;
            end else if (to_idle) begin
                bus_oe <= 1'b0;
            end
            if (to_hold && bus_rw)
                rdata <= bus_din;
        end
    end

endmodule
